// File: rtl/add_arbiter.sv
// add_arbiter: round-robin arbiter sharing one registered W-bit adder among NREQ requesters
module add_arbiter #(
    parameter int W = 8,
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_carry,
    output logic [IDW-1:0]    rsp_id
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic           found;
    logic           accept;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    int             idx;
    assign rsp_valid = (state == FULL);
    assign accept = (!rsp_valid || rsp_ready) && found && !rst;
    assign a_sel = req_a[win*W +: W];
    assign b_sel = req_b[win*W +: W];
    // first valid requester at or after ptr, wrapping
    always_comb begin
        found = 1'b0;
        win = '0;
        idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win = IDW'(idx);
            end
        end
    end
    // one-hot grant to the winner only when the result slot can take it
    always_comb begin
        req_ready = '0;
        req_ready[win] = accept;
    end
    // result register, pointer and EMPTY/FULL state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            ptr <= '0;
            rsp_sum <= '0;
            rsp_carry <= 1'b0;
            rsp_id <= '0;
        end else if (accept) begin
            state <= FULL;
            {rsp_carry, rsp_sum} <= {1'b0, a_sel} + {1'b0, b_sel};
            rsp_id <= win;
            ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
        end else if (rsp_ready) begin
            state <= EMPTY;
        end
    end
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: table-driven directed checks of add_arbiter plus async reset sequence
module tb_add_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_sum;
    logic        rsp_carry;
    logic [1:0]  rsp_id;
    int errors = 0;
    int checks = 0;

    add_arbiter #(.W(8), .NREQ(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] a;
        logic [31:0] b;
        logic        rr;
        logic [3:0]  er;
        logic        ev;
        logic [7:0]  es;
        logic        ec;
        logic [1:0]  eid;
    } vec_t;

    vec_t tv[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic ev, input logic [7:0] es, input logic ec, input logic [1:0] eid);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(ev));
        if (ev) begin
            chk({tag, " rsp_sum"}, 32'(rsp_sum), 32'(es));
            chk({tag, " rsp_carry"}, 32'(rsp_carry), 32'(ec));
            chk({tag, " rsp_id"}, 32'(rsp_id), 32'(eid));
        end
    endtask

    initial begin
        // v, a{3,2,1,0}, b{3,2,1,0}, rsp_ready, exp req_ready, exp rsp (from the previous row's accept)
        tv[0]  = '{4'b0001, 32'h00000005, 32'h0000000A, 1'b1, 4'b0001, 1'b0, 8'd0,   1'b0, 2'd0};
        tv[1]  = '{4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'd15,  1'b0, 2'd0};
        tv[2]  = '{4'b0010, 32'h0000C800, 32'h00006400, 1'b1, 4'b0010, 1'b0, 8'd0,   1'b0, 2'd0};
        tv[3]  = '{4'b0010, 32'h0000FF00, 32'h00000100, 1'b1, 4'b0010, 1'b1, 8'd44,  1'b1, 2'd1};
        tv[4]  = '{4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'd0,   1'b1, 2'd1};
        tv[5]  = '{4'b1000, 32'h01000000, 32'h02000000, 1'b1, 4'b1000, 1'b0, 8'd0,   1'b0, 2'd0};
        tv[6]  = '{4'b1111, 32'h281E140A, 32'h04030201, 1'b1, 4'b0001, 1'b1, 8'd3,   1'b0, 2'd3};
        tv[7]  = '{4'b1111, 32'h281E140A, 32'h04030201, 1'b1, 4'b0010, 1'b1, 8'd11,  1'b0, 2'd0};
        tv[8]  = '{4'b1111, 32'h281E140A, 32'h04030201, 1'b1, 4'b0100, 1'b1, 8'd22,  1'b0, 2'd1};
        tv[9]  = '{4'b1111, 32'h281E140A, 32'h04030201, 1'b1, 4'b1000, 1'b1, 8'd33,  1'b0, 2'd2};
        tv[10] = '{4'b1111, 32'h281E140A, 32'h04030201, 1'b1, 4'b0001, 1'b1, 8'd44,  1'b0, 2'd3};
        tv[11] = '{4'b1111, 32'h281E140A, 32'h04030201, 1'b1, 4'b0010, 1'b1, 8'd11,  1'b0, 2'd0};
        tv[12] = '{4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'd22,  1'b0, 2'd1};
        tv[13] = '{4'b0100, 32'h00070000, 32'h00090000, 1'b1, 4'b0100, 1'b0, 8'd0,   1'b0, 2'd0};
        tv[14] = '{4'b1111, 32'h64070101, 32'h32090101, 1'b0, 4'b0000, 1'b1, 8'd16,  1'b0, 2'd2};
        tv[15] = '{4'b1111, 32'h64070101, 32'h32090101, 1'b0, 4'b0000, 1'b1, 8'd16,  1'b0, 2'd2};
        tv[16] = '{4'b1111, 32'h64070101, 32'h32090101, 1'b0, 4'b0000, 1'b1, 8'd16,  1'b0, 2'd2};
        tv[17] = '{4'b1111, 32'h64070101, 32'h32090101, 1'b1, 4'b1000, 1'b1, 8'd16,  1'b0, 2'd2};
        tv[18] = '{4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'd150, 1'b0, 2'd3};
        tv[19] = '{4'b0100, 32'h00010000, 32'h00010000, 1'b1, 4'b0100, 1'b0, 8'd0,   1'b0, 2'd0};
        tv[20] = '{4'b1010, 32'h06000500, 32'h06000500, 1'b1, 4'b1000, 1'b1, 8'd2,   1'b0, 2'd2};
        tv[21] = '{4'b1010, 32'h06000500, 32'h06000500, 1'b1, 4'b0010, 1'b1, 8'd12,  1'b0, 2'd3};
        tv[22] = '{4'b0000, 32'h00000000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 8'd10,  1'b0, 2'd1};

        rst = 1'b1;
        req_valid = 4'b1111;
        req_a = 32'h01020304;
        req_b = 32'h05060708;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_sum", 32'(rsp_sum), 32'd0);
        chk("reset rsp_carry", 32'(rsp_carry), 32'd0);
        chk("reset rsp_id", 32'(rsp_id), 32'd0);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            rst = 1'b0;
            req_valid = tv[i].v;
            req_a = tv[i].a;
            req_b = tv[i].b;
            rsp_ready = tv[i].rr;
            #1;
            chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(tv[i].er));
            chk_rsp($sformatf("row%0d", i), tv[i].ev, tv[i].es, tv[i].ec, tv[i].eid);
        end

        // result pending, ptr=2: reset must clear outputs without a clock edge
        @(negedge clk);
        chk("pre-reset rsp_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        req_valid = 4'b0101;
        req_a = 32'h00090003;
        req_b = 32'h00090004;
        #1;
        chk("async rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async rst rsp_sum", 32'(rsp_sum), 32'd0);
        chk("async rst rsp_id", 32'(rsp_id), 32'd0);
        chk("async rst rsp_carry", 32'(rsp_carry), 32'd0);
        chk("async rst req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("post-rst req_ready", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk_rsp("post-rst", 1'b1, 8'd7, 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
